// File: rtl/integral_image_pkg.sv
// Shared definitions for the integral-image datapath and its stream neighbours.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   EOT_ROW / EOT_FRAME : bit positions inside the 2-bit end-of-transfer tag
//   eot_t               : the end-of-transfer tag carried alongside pixels
//   ii_state_t          : integral_image row-state encoding
//   cnt_width()         : counter width for a count range (never below 1 bit)
//   calc_w_ii()         : integral output width for a given pixel width and image size
package integral_image_pkg;

    localparam int EOT_ROW   = 0;
    localparam int EOT_FRAME = 1;

    typedef logic [1:0] eot_t;

    // FIRST_ROW masks the line buffer read so stale data from a previous
    // frame (or from power-up) never leaks into row 0 of a new frame.
    typedef enum logic {
        FIRST_ROW = 1'b0,
        BODY      = 1'b1
    } ii_state_t;

    // Width needed to count 0..n-1; a 1-entry range still gets one bit so
    // the counters never collapse to zero width.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Worst case ii is (2^w_data - 1) * img_w * img_h, which fits in
    // w_data + clog2(img_w) + clog2(img_h) bits.
    function automatic int calc_w_ii(input int w_data, input int img_w, input int img_h);
        return w_data + $clog2(img_w) + $clog2(img_h);
    endfunction

endpackage

// File: rtl/integral_image_line_buffer.sv
// One-row store of the previous row's integral values, indexed by column.
// Latency: writes land on the clock edge; reads are combinational (async).
// Backpressure: none; the owner gates the write enable with its own handshake.
//
// Ports:
//   clk    rising-edge clock
//   we     write enable (one entry per accepted pixel)
//   addr   column index, shared by the write and the read port
//   wdata  integral value to store at addr
//   rdata  current contents at addr (value written by the previous row)
//
// No reset on purpose: the owner masks reads during the first row of every
// frame, so the contents never need clearing and the array can map onto
// distributed RAM.
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int W     = 25,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read-before-write at the same address: the combinational read returns
    // the previous row's value during the cycle that overwrites it.
    assign rdata = mem[addr];

endmodule

// File: rtl/integral_image.sv
// Streaming integral image: ii(x,y) = sum of p(i,j) for i<=x, j<=y in the frame.
// Latency: one cycle from accepted pixel to registered dout_data/dout_eot.
// Backpressure: din_ready = ~dout_valid | dout_ready; output holds while stalled.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   din_valid   pixel valid
//   din_ready   block accepts a pixel this cycle
//   din_data    unsigned pixel
//   din_eot     [EOT_ROW] end of row, [EOT_FRAME] end of frame
//   dout_valid  integral value valid
//   dout_ready  downstream accepts
//   dout_data   integral value ii(x,y), wraps modulo 2^W_II
//   dout_eot    din_eot of the same pixel, aligned with dout_data
//   err         sticky framing error (cleared only by reset)
module integral_image
    import integral_image_pkg::*;
#(
    parameter int W_DATA = 8,
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int W_II   = calc_w_ii(W_DATA, IMG_W, IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [W_DATA-1:0] din_data,
    input  logic [1:0]        din_eot,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [W_II-1:0]   dout_data,
    output logic [1:0]        dout_eot,
    output logic              err
);

    localparam int XW = cnt_width(IMG_W);
    localparam int YW = cnt_width(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    ii_state_t       state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [W_II-1:0] row_sum;

    logic            xfer;
    logic            last_col;
    logic            last_row;
    logic            eot_row;
    logic            eot_frame;
    logic            row_end;
    logic            frame_end;
    logic            eot_err;
    logic [W_II-1:0] din_ext;
    logic [W_II-1:0] lb_rd;
    logic [W_II-1:0] above;
    logic [W_II-1:0] ii;

    // ------------------------------------------------------------------
    // Handshake: a single output register, so input is accepted whenever
    // that register is empty or draining this cycle.
    // ------------------------------------------------------------------
    assign din_ready = ~dout_valid | dout_ready;
    assign xfer      = din_valid & din_ready;

    // ------------------------------------------------------------------
    // Framing decode
    // ------------------------------------------------------------------
    assign last_col  = (x == X_LAST);
    assign last_row  = (y == Y_LAST);
    assign eot_row   = din_eot[EOT_ROW];
    assign eot_frame = din_eot[EOT_FRAME];

    // A row ends either on the geometric last column or when the source
    // flags it early; an early flag is an error but is still honoured so
    // the counters resynchronise to the source's framing.
    assign row_end   = last_col | eot_row;
    assign frame_end = (row_end & last_row) | eot_frame;

    assign eot_err   = (eot_row & ~last_col)
                     | (last_col & ~eot_row)
                     | (eot_frame & ~(last_col & last_row));

    // ------------------------------------------------------------------
    // Datapath. The sum is W_II bits wide and wraps silently; the pixel is
    // resized to W_II so a narrow W_II truncates consistently.
    // ------------------------------------------------------------------
    assign din_ext = W_II'(din_data);
    assign above   = (state == FIRST_ROW) ? '0 : lb_rd;
    assign ii      = row_sum + din_ext + above;

    line_buffer #(
        .DEPTH (IMG_W),
        .W     (W_II),
        .AW    (XW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (xfer),
        .addr  (x),
        .wdata (ii),
        .rdata (lb_rd)
    );

    // ------------------------------------------------------------------
    // Row/frame state machine, counters and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FIRST_ROW;
            x          <= '0;
            y          <= '0;
            row_sum    <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_eot   <= '0;
            err        <= 1'b0;
        end else begin
            if (xfer) begin
                dout_valid <= 1'b1;
                dout_data  <= ii;
                dout_eot   <= din_eot;

                if (frame_end) begin
                    // Line buffer is left as is; FIRST_ROW masks it.
                    state   <= FIRST_ROW;
                    x       <= '0;
                    y       <= '0;
                    row_sum <= '0;
                end else if (row_end) begin
                    state   <= BODY;
                    x       <= '0;
                    y       <= y + 1'b1;
                    row_sum <= '0;
                end else begin
                    x       <= x + 1'b1;
                    row_sum <= row_sum + din_ext;
                end

                if (eot_err) begin
                    err <= 1'b1;
                end
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_integral_image.sv
`timescale 1ns/1ps
module tb_integral_image;
    import integral_image_pkg::*;

    localparam int W_DATA = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int W_II   = calc_w_ii(W_DATA, IMG_W, IMG_H);
    localparam logic [31:0] MASK  = 32'((64'd1 << W_II) - 1);
    localparam logic [31:0] MASK4 = 32'h0000_000F;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              din_valid = 1'b0;
    logic [W_DATA-1:0] din_data = '0;
    logic [1:0]        din_eot = '0;
    logic              dout_ready = 1'b1;

    logic              din_ready, dout_valid, err;
    logic [W_II-1:0]   dout_data;
    logic [1:0]        dout_eot;

    // Narrow-output twin driven in lockstep to exercise wrap-around.
    logic              din_ready4, dout_valid4, err4;
    logic [3:0]        dout_data4;
    logic [1:0]        dout_eot4;

    integral_image #(.W_DATA(W_DATA), .IMG_W(IMG_W), .IMG_H(IMG_H), .W_II(W_II)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready),
        .din_data(din_data), .din_eot(din_eot), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_data(dout_data), .dout_eot(dout_eot), .err(err)
    );

    integral_image #(.W_DATA(W_DATA), .IMG_W(IMG_W), .IMG_H(IMG_H), .W_II(4)) dut4 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready4),
        .din_data(din_data), .din_eot(din_eot), .dout_valid(dout_valid4),
        .dout_ready(dout_ready), .dout_data(dout_data4), .dout_eot(dout_eot4), .err(err4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  eot;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          out_cnt  = 0;
    int          stall_base = 0;
    logic        stall_en = 1'b0;
    logic [7:0]  frm [IMG_H][IMG_W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every accepted output is compared against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && dout_valid && dout_ready) begin
            check("sb_nonempty", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("dout_data", 32'(dout_data), e.data);
                check("dout_eot", 32'(dout_eot), 32'(e.eot));
                check("w4_valid", 32'(dout_valid4), 1);
                check("w4_data", 32'(dout_data4), e.data & MASK4);
                out_cnt++;
            end
        end
    end

    // Downstream stall: drop dout_ready for 3 cycles while the 5th output of
    // the stall frame is presented, checking that it holds.
    initial begin
        int c;
        wait (stall_en);
        c = 0;
        while (out_cnt < stall_base + 4 && c < 500) begin
            @(posedge clk);
            c++;
        end
        check("stall_reached", 32'(out_cnt >= stall_base + 4), 1);
        #1 dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(dout_valid), 1);
            check("hold_data", 32'(dout_data), 2);
            check("hold_din_ready", 32'(din_ready), 0);
            @(posedge clk);
        end
        #1 dout_ready = 1'b1;
    end

    // Global bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Drive one pixel; caller must be just after a rising edge.
    task automatic send_px(input logic [7:0] d, input logic [1:0] eot, input logic [31:0] exp);
        int c;
        din_valid = 1'b1;
        din_data  = d;
        din_eot   = eot;
        c = 0;
        @(negedge clk);
        while (!din_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("din_accept", 32'(din_ready), 1);
        sbq.push_back('{data: exp & MASK, eot: eot});
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_eot   = '0;
    endtask

    function automatic logic [31:0] prefix(input int px, input int py);
        logic [31:0] s;
        s = 0;
        for (int j = 0; j <= py; j++)
            for (int i = 0; i <= px; i++)
                s += 32'(frm[j][i]);
        return s;
    endfunction

    task automatic fill(input int v);
        for (int j = 0; j < IMG_H; j++)
            for (int i = 0; i < IMG_W; i++)
                frm[j][i] = (v < 0) ? 8'($urandom_range(0, 255)) : 8'(v);
    endtask

    // Rows from first_row onward, with correct eot marks unless row0_noeot.
    task automatic send_rows(input int first_row, input logic row0_noeot);
        logic [1:0] eot;
        for (int j = first_row; j < IMG_H; j++)
            for (int i = 0; i < IMG_W; i++) begin
                eot = {(j == IMG_H-1 && i == IMG_W-1), (i == IMG_W-1)};
                if (row0_noeot && j == 0) eot = 2'b00;
                send_px(frm[j][i], eot, prefix(i, j));
            end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((sbq.size() != 0 || dout_valid) && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("drain", 32'(sbq.size()), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        din_valid = 1'b0;
        #1;
        check("rst_dout_valid", 32'(dout_valid), 0);
        check("rst_dout_data", 32'(dout_data), 0);
        check("rst_dout_eot", 32'(dout_eot), 0);
        check("rst_err", 32'(err), 0);
        check("rst_din_ready", 32'(din_ready), 1);
        sbq.delete();
        repeat (2) @(negedge clk);
        check("rst_din_ready_hold", 32'(din_ready), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_din_ready", 32'(din_ready), 1);
    endtask

    initial begin
        do_reset();

        // All-ones frame: 1,2,3,4,2,4,6,8,3,6,9,12, last eot 2'b11, no error.
        fill(1);
        send_rows(0, 1'b0);
        drain();
        check("ones_err", 32'(err), 0);

        // Same frame with a 3-cycle downstream stall on the 5th output.
        stall_base = out_cnt;
        stall_en = 1'b1;
        send_rows(0, 1'b0);
        drain();

        // All-255 frame: the 4-bit twin wraps (row 0 reads 15,14,13,12).
        fill(255);
        send_rows(0, 1'b0);
        drain();
        check("wrap_err", 32'(err), 0);

        // Two back-to-back random frames must produce identical results,
        // proving row 0 of frame 2 ignores frame 1's line buffer.
        fill(-1);
        send_rows(0, 1'b0);
        send_rows(0, 1'b0);
        drain();

        // Early end-of-row on the 3rd pixel of row 0, then row 1 begins.
        send_px(8'd1, 2'b00, 1);
        send_px(8'd1, 2'b00, 2);
        check("err_before_early_eot", 32'(err), 0);
        send_px(8'd1, 2'b01, 3);
        check("err_early_row", 32'(err), 1);
        send_px(8'd1, 2'b00, 2);
        send_px(8'd1, 2'b00, 4);
        drain();
        check("err_sticky", 32'(err), 1);

        // Reset mid-frame after 6 pixels, then a full all-twos frame.
        do_reset();
        fill(1);
        for (int k = 0; k < 6; k++)
            send_px(8'd1, (k == 3) ? 2'b01 : 2'b00, prefix(k % IMG_W, k / IMG_W));
        check("pre_rst_valid", 32'(dout_valid), 1);
        do_reset();
        fill(2);
        send_rows(0, 1'b0);
        drain();
        check("twos_err", 32'(err), 0);

        // Row end without its eot flag flags an error; framing continues.
        fill(3);
        send_rows(0, 1'b1);
        drain();
        check("err_missing_eot", 32'(err), 1);

        // Early end-of-frame on the first pixel, then a clean frame restarts at p(0,0).
        do_reset();
        send_px(8'd5, 2'b10, 5);
        check("err_early_frame", 32'(err), 1);
        fill(1);
        send_rows(0, 1'b0);
        drain();
        check("err_still_set", 32'(err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
